// File: rtl/core_3do_pkg.sv
// Shared constants and types for the core_3do bus responder: address map,
// register window layout, CSTATBITS masks and the responder FSM encoding.
package core_3do_pkg;

    // Region decode: an address belongs to a region when (adr & MASK) == BASE
    localparam logic [31:0] DRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] DRAM_MASK = 32'hFFE0_0000;   // 2 MiB
    localparam logic [31:0] ROM_BASE  = 32'h0300_0000;
    localparam logic [31:0] ROM_MASK  = 32'hFFF0_0000;   // 1 MiB
    localparam logic [31:0] REG_BASE  = 32'h0340_0000;
    localparam logic [31:0] REG_MASK  = 32'hFFFF_FF00;   // 256 B window

    // Byte offsets inside the register window
    localparam logic [7:0] REG_REVISION_OFS = 8'h00;
    localparam logic [7:0] REG_CSTAT_OFS    = 8'h28;

    // Read data for accesses that hit no region
    localparam logic [31:0] UNMAPPED_DATA = 32'hBAD0_BAD0;

    // CSTATBITS reset value, event flags and software write masks
    localparam logic [10:0] CSTAT_RESET         = 11'h001;
    localparam logic [10:0] CSTAT_WDGRST        = 11'h002;
    localparam logic [10:0] CSTAT_DIPIR         = 11'h040;
    localparam logic [10:0] CSTAT_WRITE_MASK    = 11'h063;
    localparam logic [10:0] CSTAT_PRESERVE_MASK = 11'h010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_ACK
    } state_t;

    typedef enum logic [1:0] {
        REGION_DRAM,
        REGION_ROM,
        REGION_REG,
        REGION_NONE
    } region_t;

    function automatic region_t decode_region(input logic [31:0] adr);
        if ((adr & DRAM_MASK) == DRAM_BASE) return REGION_DRAM;
        if ((adr & ROM_MASK)  == ROM_BASE)  return REGION_ROM;
        if ((adr & REG_MASK)  == REG_BASE)  return REGION_REG;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/wb_resp_regbank.sv
// Local register window: REVISION (read-only) and CSTATBITS with its
// event-flag priority logic. Provides the read mux for the window.
module wb_resp_regbank
    import core_3do_pkg::*;
#(
    parameter logic [31:0] REVISION = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wdgrst,
    input  logic        dipir,
    input  logic        wr_en,
    input  logic [10:0] wr_data,
    input  logic [5:0]  word,
    output logic [31:0] rd_data,
    output logic [10:0] cstatbits
);

    localparam logic [5:0] REVISION_WORD = REG_REVISION_OFS[7:2];
    localparam logic [5:0] CSTAT_WORD    = REG_CSTAT_OFS[7:2];

    logic [10:0] cstat;

    // CSTATBITS: one update per cycle; events win over a coincident write
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            cstat <= CSTAT_RESET;
        end else if (wdgrst) begin
            cstat <= cstat | CSTAT_WDGRST;
        end else if (dipir) begin
            cstat <= cstat | CSTAT_DIPIR;
        end else if (wr_en && (word == CSTAT_WORD)) begin
            cstat <= (cstat & (wr_data & CSTAT_WRITE_MASK)) | (wr_data & CSTAT_PRESERVE_MASK);
        end
    end

    // Read mux: unused offsets in the window read as zero
    always_comb begin
        // NOTE: default first so no path leaves rd_data unassigned (no latch).
        rd_data = '0;
        if (word == REVISION_WORD) begin
            rd_data = REVISION;
        end else if (word == CSTAT_WORD) begin
            rd_data = {21'd0, cstat};
        end
    end

    assign cstatbits = cstat;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 classic responder for the zap_top CPU bus. Decodes DRAM, ROM
// and the local register window, forwards memory traffic to a
// variable-latency backend and answers every access with one ack.
module wb_mem_responder
    import core_3do_pkg::*;
#(
    parameter logic [31:0] REVISION      = 32'h0100_0000,
    parameter logic [31:0] UNMAPPED_DATA = core_3do_pkg::UNMAPPED_DATA
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic [2:0]  i_wb_cti,
    input  logic [1:0]  i_wb_bte,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat,
    output logic        o_mem_req,
    output logic        o_mem_rom,
    output logic [21:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    input  logic        i_wdgrst,
    input  logic        i_dipir,
    output logic [10:0] o_cstatbits,
    output logic        o_bus_err
);

    state_t      state;
    region_t     region;
    logic        access;
    logic        to_backend;
    logic        aborted;
    logic        cstat_wr;
    logic [21:0] mem_addr_next;
    logic [31:0] reg_rd_data;
    logic [31:0] resp_data;
    logic        unused_bits;

    // Burst controls are ignored (every beat is classic); byte offset is ignored
    assign unused_bits = ^{i_wb_cti, i_wb_bte, i_wb_adr[1:0]};

    assign access     = i_wb_cyc & i_wb_stb;
    assign region     = decode_region(i_wb_adr);
    assign to_backend = (region == REGION_DRAM) | ((region == REGION_ROM) & ~i_wb_we);
    assign cstat_wr   = (state == ST_IDLE) & access & i_wb_we & i_wb_sel[0]
                      & (region == REGION_REG);

    wb_resp_regbank #(
        .REVISION (REVISION)
    ) u_regbank (
        .clk       (i_clk),
        .reset     (i_reset),
        .wdgrst    (i_wdgrst),
        .dipir     (i_dipir),
        .wr_en     (cstat_wr),
        .wr_data   (i_wb_dat[10:0]),
        .word      (i_wb_adr[7:2]),
        .rd_data   (reg_rd_data),
        .cstatbits (o_cstatbits)
    );

    // Word address within the selected backend target
    always_comb begin
        mem_addr_next = '0;
        if (region == REGION_ROM) begin
            mem_addr_next = {4'd0, i_wb_adr[19:2]};
        end else begin
            mem_addr_next = {3'd0, i_wb_adr[20:2]};
        end
    end

    // Immediate response for accesses answered without the backend
    always_comb begin
        resp_data = '0;
        if (!i_wb_we) begin
            case (region)
                REGION_REG:  resp_data = reg_rd_data;
                REGION_NONE: resp_data = UNMAPPED_DATA;
                default:     resp_data = '0;
            endcase
        end
    end

    // Responder FSM with registered bus and backend outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            aborted     <= 1'b0;
            o_wb_ack    <= 1'b0;
            o_wb_dat    <= '0;
            o_bus_err   <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_rom   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_wb_ack  <= 1'b0;
                    o_wb_dat  <= '0;
                    o_bus_err <= 1'b0;
                    if (access) begin
                        if (to_backend) begin
                            o_mem_req   <= 1'b1;
                            o_mem_rom   <= (region == REGION_ROM);
                            o_mem_addr  <= mem_addr_next;
                            o_mem_we    <= i_wb_we;
                            o_mem_be    <= i_wb_sel;
                            o_mem_wdata <= i_wb_dat;
                            aborted     <= 1'b0;
                            state       <= ST_MEM_WAIT;
                        end else begin
                            o_wb_ack  <= 1'b1;
                            o_wb_dat  <= resp_data;
                            o_bus_err <= (region == REGION_NONE);
                            state     <= ST_ACK;
                        end
                    end
                end

                ST_MEM_WAIT: begin
                    // The request stays up until the backend completes; an
                    // abort only suppresses the ack, even if cyc returns.
                    if (i_mem_ready) begin
                        o_mem_req <= 1'b0;
                        aborted   <= 1'b0;
                        if (i_wb_cyc && !aborted) begin
                            o_wb_ack <= 1'b1;
                            o_wb_dat <= i_mem_rdata;
                            state    <= ST_ACK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!i_wb_cyc) begin
                        aborted <= 1'b1;
                    end
                end

                ST_ACK: begin
                    // Bus deliberately not sampled here: a held strobe cannot double-ack
                    o_wb_ack  <= 1'b0;
                    o_wb_dat  <= '0;
                    o_bus_err <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Wishbone B4 classic-cycle responder that terminates the bus mastered by the `zap_top` CPU inside `core_3do`. It decodes each CPU access to one of three targets: DRAM, BIOS ROM, or a small local register window (revision, CSTATBITS). DRAM and ROM accesses are forwarded to a variable-latency backend memory port. Every access is answered with exactly one `o_wb_ack` pulse, including unmapped addresses and writes that are dropped.

## Interface
Parameters:
- `REVISION`, `32'h0100_0000`: value returned by the revision register.
- `UNMAPPED_DATA`, `32'hBAD0_BAD0`: read data returned for unmapped addresses.

Ports:
- `i_clk` in 1: the single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_wb_cyc`, `i_wb_stb` in 1 each: Wishbone cycle and strobe.
- `i_wb_we` in 1: write enable.
- `i_wb_adr` in 32: byte address. Bits [1:0] are ignored.
- `i_wb_dat` in 32: write data.
- `i_wb_sel` in 4: byte lane enables.
- `i_wb_cti` in 3 and `i_wb_bte` in 2: accepted and ignored. Every beat is handled as classic.
- `o_wb_ack` out 1: single-cycle acknowledge.
- `o_wb_dat` out 32: read data, valid only while `o_wb_ack` is high.
- `o_mem_req` out 1: backend request, held until `i_mem_ready`.
- `o_mem_rom` out 1: 1 selects ROM, 0 selects DRAM.
- `o_mem_addr` out 22: word address within the selected target.
- `o_mem_we` out 1, `o_mem_be` out 4, `o_mem_wdata` out 32: backend write controls and data.
- `i_mem_rdata` in 32 and `i_mem_ready` in 1: backend completion. Ready is a one-cycle pulse.
- `i_wdgrst` in 1 and `i_dipir` in 1: event pulses that set CSTATBITS flags.
- `o_cstatbits` out 11: live CSTATBITS value.
- `o_bus_err` out 1: one-cycle pulse on an unmapped access.

## Operation
Address map:
- DRAM: `0x0000_0000`–`0x001F_FFFF`, read/write.
- ROM: `0x0300_0000`–`0x030F_FFFF`, read-only. Writes are acked and dropped; no backend request is issued.
- Register window: `0x0340_0000`–`0x0340_00FF`.
  - Offset `0x00`: REVISION, read-only.
  - Offset `0x28`: CSTATBITS.
  - Any other offset reads 0 and ignores writes. These offsets do not raise `o_bus_err`.
- Anything else is unmapped: reads return `UNMAPPED_DATA` and `o_bus_err` pulses.

State machine has three states: `IDLE`, `MEM_WAIT`, `ACK`.
- **`IDLE`**, when `cyc & stb`:
  - DRAM, or ROM read: latch the backend request fields, assert `o_mem_req`, go to `MEM_WAIT`.
  - Register access, ROM write, or unmapped access: compute the response and go to `ACK`.
- **`MEM_WAIT`**: when `i_mem_ready` is high, capture `i_mem_rdata`, drop `o_mem_req`, go to `ACK`.
- **`ACK`**: `o_wb_ack` is high for this one cycle; next state is `IDLE`. The bus is not sampled in `ACK`, so a transaction whose strobe is still high in that cycle cannot be acked twice.

CSTATBITS update, applied once per cycle in this priority order:
1. `i_reset`: value becomes `11'h001`.
2. `i_wdgrst`: `|= 11'h002`.
3. `i_dipir`: `|= 11'h040`.
4. Register write with `i_wb_sel[0]` set: `(cstat & (wdat & 11'h063)) | (wdat & 11'h010)`.
- Because of this ordering, a write coinciding with a `wdgrst` or `dipir` event is lost.
- Register writes with `i_wb_sel[0]` clear are ignored.

Abort handling (`cyc` dropped while in `MEM_WAIT`):
- The backend request is held until `i_mem_ready`; it is not cancelled.
- The result is discarded, and the FSM goes directly to `IDLE` with no ack.
- A new `stb` arriving during this wait is serviced only after the FSM returns to `IDLE`.

Reset values:
- All outputs are 0, except `o_cstatbits`, which is `11'h001`.
- FSM is in `IDLE`.
- Reset during `MEM_WAIT` drops `o_mem_req` immediately. The backend is required to tolerate an abandoned request.

## Timing
- Register, ROM-write and unmapped accesses: `stb` sampled at edge N, `o_wb_ack` high in cycle N+1. This is 1-cycle latency.
- DRAM and ROM reads: `o_mem_req` rises in cycle N+1. If `i_mem_ready` is seen at edge M, `o_wb_ack` is high in cycle M+1. Minimum latency is 2 cycles.
- Back-to-back transactions: at most one ack every 2 cycles.
- `o_mem_*` fields are stable for the whole time `o_mem_req` is high.
- `o_wb_dat` is 0 whenever `o_wb_ack` is low.

## Structure
- `core_3do_pkg` holds:
  - region base and mask constants;
  - register offsets;
  - `UNMAPPED_DATA`;
  - the CSTATBITS write and preserve masks (`11'h063`, `11'h010`);
  - the FSM state enum.
- One sub-module, `wb_resp_regbank`, holds the CSTATBITS register and the event-priority logic. It provides read-mux output for the register window.

## Test plan
1. **DRAM read with latency.** Read `0x0000_1000`, backend returns `0xDEADBEEF` with ready 3 cycles after the request → exactly one ack, data `0xDEADBEEF`, `o_mem_addr = 0x400`.
2. **ROM write dropped.** Write to `0x0300_0010` → ack in the next cycle, `o_mem_req` never asserted. A following ROM read of the same address returns the backend value.
3. **CSTATBITS sequence.** After reset, read → `0x001`. Then pulse `i_dipir` → reads `0x041`. Then write `0x013` with sel `0xF` → reads `0x011`. Then write with a simultaneous `i_wdgrst` → reads `0x013`.
4. **Unmapped read.** Read `0x0500_0000` → ack with data `0xBAD0BAD0` and a one-cycle `o_bus_err` pulse in the same cycle.
5. **Abort during wait.** Drop `cyc` during `MEM_WAIT` with ready arriving 4 cycles later → no ack. The next read to `0x0340_0000` returns `REVISION` with 1-cycle latency measured from `IDLE`.
6. **Held strobe, no double ack.** Two back-to-back register reads with `stb` held continuously → acks in alternating cycles, exactly 2 acks total. Then assert reset during `MEM_WAIT` → `o_mem_req` is 0 in the next cycle.
